// File: rtl/cpu_params_pkg.sv
// Shared CPU build parameters: address/line geometry, fill FSM states and tag sizing.
package cpu_params_pkg;

    localparam int unsigned CPU_PC_SZ  = 32;
    localparam int unsigned CPU_CL_LEN = 32;
    localparam int unsigned CL_WORDS   = CPU_CL_LEN / 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        ACK  = 2'd2
    } ic_state_e;

    function automatic int unsigned cl_words(input int unsigned cl_len);
        return cl_len / 4;
    endfunction

    function automatic int unsigned tag_width(input int unsigned pc_sz, input int unsigned cl_len);
        return pc_sz - $clog2(cl_len);
    endfunction

endpackage

// File: rtl/ic_fill_ctrl.sv
// Instruction-cache line fill controller: one-line buffer between the core's
// fetch port and a word-wide block RAM, refilled one word per memory handshake.
module ic_fill_ctrl
    import cpu_params_pkg::*;
#(
    parameter int unsigned PC_SZ  = CPU_PC_SZ,
    parameter int unsigned CL_LEN = CPU_CL_LEN
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                ic_req,
    input  logic [PC_SZ-1:0]    ic_addr,
    input  logic                ic_flush,
    output logic                ic_ack,
    output logic [CL_LEN*8-1:0] ic_ack_data,
    output logic                mem_req,
    output logic [PC_SZ-1:0]    mem_addr,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rd_data
);

    localparam int unsigned N_WORDS = cl_words(CL_LEN);
    localparam int unsigned OFF_W   = $clog2(CL_LEN);
    localparam int unsigned TAG_W   = tag_width(PC_SZ, CL_LEN);
    localparam int unsigned CNT_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(N_WORDS - 1);

    ic_state_e          state_q, state_d;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [PC_SZ-1:0]   base_q, base_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic [PC_SZ-1:0]   mem_addr_q, mem_addr_d;
    logic               ic_ack_q, ic_ack_d;
    logic               flushed_q, flushed_d;
    logic               dropped_q, dropped_d;
    logic [31:0]        line_q [N_WORDS];

    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic               beat;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               unused_addr_bits;

    assign req_tag          = ic_addr[PC_SZ-1:OFF_W];
    assign unused_addr_bits = ^ic_addr[OFF_W-1:0];
    assign hit              = valid_q && (tag_q == req_tag);
    assign beat             = (state_q == FILL) && mem_req_q && mem_ack;
    assign cnt_nxt          = CNT_W'(cnt_q + 1'b1);

    assign ic_ack   = ic_ack_q;
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;

    // State and control registers
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            tag_q      <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            ic_ack_q   <= 1'b0;
            flushed_q  <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            ic_ack_q   <= ic_ack_d;
            flushed_q  <= flushed_d;
            dropped_q  <= dropped_d;
        end
    end

    // Line data is deliberately not reset; a beat arriving during reset is dropped
    always_ff @(posedge clk_in) begin
        if (beat && !reset_in) begin
            line_q[cnt_q] <= mem_rd_data;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        ic_ack_d   = 1'b0;
        flushed_d  = flushed_q;
        dropped_d  = dropped_q;

        unique case (state_q)
            IDLE: begin
                if (ic_req && !ic_flush && hit) begin
                    state_d  = ACK;
                    ic_ack_d = 1'b1;
                end else if (ic_req) begin
                    base_d     = {req_tag, {OFF_W{1'b0}}};
                    cnt_d      = '0;
                    valid_d    = 1'b0;
                    flushed_d  = 1'b0;
                    dropped_d  = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {req_tag, {OFF_W{1'b0}}};
                    state_d    = FILL;
                end else if (ic_flush) begin
                    valid_d = 1'b0;
                end
            end

            FILL: begin
                if (ic_flush) flushed_d = 1'b1;
                if (!ic_req)  dropped_d = 1'b1;
                if (beat) begin
                    cnt_d = cnt_nxt;
                    if (cnt_q == LAST_WORD) begin
                        mem_req_d = 1'b0;
                        valid_d   = !(flushed_q || ic_flush);
                        tag_d     = base_q[PC_SZ-1:OFF_W];
                        // A requester that walked away still gets the line buffered
                        if (dropped_q || !ic_req) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = ACK;
                            ic_ack_d = 1'b1;
                        end
                    end else begin
                        mem_addr_d = base_q + (PC_SZ'(cnt_nxt) << 2);
                    end
                end
            end

            ACK: begin
                state_d = IDLE;
                if (ic_flush) valid_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ic_ack_data = '0;
        for (int i = 0; i < N_WORDS; i++) begin
            ic_ack_data[32*i +: 32] = line_q[i];
        end
    end

endmodule

// File: tb/tb_ic_fill_ctrl.sv
// Scoreboard bench for ic_fill_ctrl: stimulus queues expected memory beats and
// delivered lines; a negedge monitor pops and compares them as the DUT presents them.
module tb_ic_fill_ctrl;

    logic         clk = 1'b0;
    logic         reset_in;
    logic         ic_req;
    logic [31:0]  ic_addr;
    logic         ic_flush;
    logic         ic_ack;
    logic [255:0] ic_ack_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rd_data;

    logic         resp_ack = 1'b0;
    logic         force_ack = 1'b0;
    int           lat_max = 2;
    int           wait_cnt = 0;

    int           total = 0;
    int           bad = 0;
    int           beats = 0;

    logic [31:0]  exp_addr [$];
    logic [255:0] exp_line [$];
    logic [31:0]  e_addr;
    logic [255:0] e_line;
    logic         prev_wait = 1'b0;
    logic [31:0]  prev_addr = '0;

    logic         model_valid = 1'b0;
    logic [31:0]  model_base = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1234_5678;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] base);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = ram_word(base + 32'(4 * i));
        return l;
    endfunction

    assign mem_rd_data = ram_word(mem_addr);
    assign mem_ack     = resp_ack | force_ack;

    ic_fill_ctrl dut (
        .clk_in      (clk),
        .reset_in    (reset_in),
        .ic_req      (ic_req),
        .ic_addr     (ic_addr),
        .ic_flush    (ic_flush),
        .ic_ack      (ic_ack),
        .ic_ack_data (ic_ack_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rd_data (mem_rd_data)
    );

    // Backing RAM responder with 0..lat_max cycles of latency per word
    initial forever begin
        @(posedge clk); #1;
        if (resp_ack) wait_cnt = int'($urandom_range(lat_max, 0));
        if (mem_req) begin
            if (wait_cnt == 0) resp_ack = 1'b1;
            else begin
                resp_ack = 1'b0;
                wait_cnt--;
            end
        end else begin
            resp_ack = 1'b0;
        end
    end

    // Monitor: compare memory beats, address stability and delivered lines
    always @(negedge clk) begin
        if (!reset_in) begin
            if (prev_wait) begin
                total++;
                if (!mem_req || mem_addr != prev_addr) begin
                    bad++;
                    $display("FAIL addr_stable: req=%0b addr=%h required req=1 addr=%h", mem_req, mem_addr, prev_addr);
                end
            end
            if (mem_req && mem_ack) begin
                beats++;
                total++;
                if (exp_addr.size() == 0) begin
                    bad++;
                    $display("FAIL mem_beat: unexpected read of %h, none required", mem_addr);
                end else begin
                    e_addr = exp_addr.pop_front();
                    if (mem_addr != e_addr) begin
                        bad++;
                        $display("FAIL mem_addr: got %h required %h", mem_addr, e_addr);
                    end
                end
            end
            if (ic_ack) begin
                total++;
                if (exp_line.size() == 0) begin
                    bad++;
                    $display("FAIL ic_ack: unexpected ack with data %h", ic_ack_data);
                end else begin
                    e_line = exp_line.pop_front();
                    if (ic_ack_data != e_line) begin
                        bad++;
                        $display("FAIL ack_data: got %h required %h", ic_ack_data, e_line);
                    end
                end
            end
            prev_wait = mem_req && !mem_ack;
            prev_addr = mem_addr;
        end else begin
            prev_wait = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic push_fill(input logic [31:0] base);
        for (int i = 0; i < 8; i++) exp_addr.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_beats(input int k);
        int target = beats + k;
        int n = 0;
        while (n < 300 && beats < target) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (beats < target) begin
            bad++;
            $display("FAIL beat_timeout: got %0d beats required %0d", beats, target);
        end
    endtask

    task automatic wait_ack(input bit chk_hit);
        int n = 0;
        bit got = 1'b0;
        while (n < 400 && !got) begin
            @(posedge clk); #1;
            n++;
            got = ic_ack;
        end
        ic_req = 1'b0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL ack_timeout: no ic_ack within %0d cycles", n);
        end else begin
            if (chk_hit) check("hit_latency", 32'(n), 32'd1);
            @(posedge clk); #1;
            check("ack_pulse", 32'(ic_ack), 32'd0);
        end
    endtask

    task automatic pulse_flush();
        ic_flush = 1'b1;
        @(posedge clk); #1;
        ic_flush = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        logic [31:0] b = a & ~32'h1F;
        bit hit = model_valid && (model_base == b);
        if (!hit) push_fill(b);
        exp_line.push_back(line_of(b));
        ic_addr = a;
        ic_req  = 1'b1;
        wait_ack(hit);
        model_valid = 1'b1;
        model_base  = b;
    endtask

    initial begin
        reset_in = 1'b1;
        ic_req   = 1'b0;
        ic_addr  = '0;
        ic_flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ic_ack", 32'(ic_ack), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        reset_in = 1'b0;
        @(posedge clk); #1;

        // Cold miss, then hit on same line
        fetch(32'h0000_0044);
        fetch(32'h0000_0058);

        // Flush in idle forces a full refill
        pulse_flush();
        model_valid = 1'b0;
        fetch(32'h0000_0040);

        // Flush during fill: line still delivered but not retained
        push_fill(32'h80);
        exp_line.push_back(line_of(32'h80));
        ic_addr = 32'h80;
        ic_req  = 1'b1;
        wait_beats(3);
        pulse_flush();
        wait_ack(1'b0);
        model_valid = 1'b0;
        fetch(32'h0000_0084);

        // Requester drops mid-fill: line buffered, no ack, later hit
        push_fill(32'h100);
        ic_addr = 32'h104;
        ic_req  = 1'b1;
        wait_beats(2);
        ic_req = 1'b0;
        wait_beats(6);
        repeat (4) @(posedge clk);
        #1;
        model_valid = 1'b1;
        model_base  = 32'h100;
        fetch(32'h0000_011C);

        // Reset mid-fill with mem_ack held high through reset
        lat_max = 0;
        push_fill(32'h200);
        ic_addr = 32'h200;
        ic_req  = 1'b1;
        wait_beats(2);
        reset_in  = 1'b1;
        force_ack = 1'b1;
        ic_req    = 1'b0;
        @(posedge clk); #1;
        check("rmid_mem_req", 32'(mem_req), 32'd0);
        check("rmid_ic_ack", 32'(ic_ack), 32'd0);
        @(posedge clk); #1;
        reset_in  = 1'b0;
        force_ack = 1'b0;
        exp_addr.delete();
        model_valid = 1'b0;
        fetch(32'h0000_0200);

        // Random latency across 100 requests over a small set of lines
        lat_max = 5;
        for (int n = 0; n < 100; n++) begin
            logic [31:0] a;
            a = 32'h1000 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2);
            if (n % 3 == 0) begin
                pulse_flush();
                model_valid = 1'b0;
            end
            fetch(a);
        end

        repeat (5) @(posedge clk);
        #1;
        check("exp_addr_left", 32'(exp_addr.size()), 32'd0);
        check("exp_line_left", 32'(exp_line.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
